// File: rtl/gen_ram.sv
// ---------------------------------------------------------------------------
// gen_ram
//   Generic single-port synchronous RAM, 2**AW words x DW bits, used as MIPS
//   data or instruction storage. One shared address bus carries every access.
//   Each cycle the rw strobe selects a single operation:
//     - a write stores data_in at addr, or
//     - a read loads mem[addr] into the registered data_out.
//   An asynchronous active-low reset clears the whole array and data_out.
//
// Ports
//   clk       in   1    system clock, rising-edge active
//   rst_n     in   1    asynchronous active-low reset
//   addr      in   AW   word address, full range 0 .. 2**AW-1
//   rw        in   1    1 = read, 0 = write
//   data_in   in   DW   write data, sampled when rw = 0
//   data_out  out  DW   registered read data, 1-cycle latency
// ---------------------------------------------------------------------------
module gen_ram #(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr,
    input  logic          rw,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] data_out_q;
    logic [DW-1:0] data_out_d;

    // The output register loads only on a read.
    // On a write it holds its value, so there is no write-through.
    always_comb begin
        // NOTE: default assignment first so no path leaves data_out_d unassigned (no latch).
        data_out_d = data_out_q;
        if (rw) begin
            data_out_d = mem_q[addr];
        end
    end

    // Storage. addr spans the depth exactly, so no wrap or aliasing is possible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the array sits in the async reset on purpose: contents must read 0
            // after any reset. That rules out mapping onto a RAM macro without reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (!rw) begin
            // NOTE: non-blocking assignment for all sequential state, so a read in the
            // same block sees the pre-edge value.
            mem_q[addr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_gen_ram.sv
// ---------------------------------------------------------------------------
// tb_gen_ram
//   Self-checking bench for gen_ram (AW = 4, DW = 32).
//   A stimulus process drives one operation per cycle on the falling edge.
//   For each operation it pushes the value data_out must show after the next
//   rising edge onto a scoreboard queue.
//   The reference model is a plain array plus the last value read.
//   A monitor pops one entry shortly after each rising edge and compares it
//   with data_out. A write must leave data_out at the last value read.
//   Async reset behaviour is checked directly while rst_n is low.
// ---------------------------------------------------------------------------
module tb_gen_ram;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] addr;
    logic          rw;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;

    gen_ram #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .rw       (rw),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [DW-1:0] value;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] ref_out;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: data_out=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic ref_clear();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        ref_out = '0;
    endtask

    // One operation. It is driven on the falling edge and sampled at the next rising edge.
    task automatic do_op(input logic op_rw, input int a, input logic [DW-1:0] d, input string name);
        exp_t e;
        @(negedge clk);
        rw      = op_rw;
        addr    = AW'(a);
        data_in = d;
        if (op_rw) ref_out = ref_mem[a];
        else       ref_mem[a] = d;
        e.name  = name;
        e.value = ref_out;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
            sb_q.delete();
        end
        #3;
    endtask

    // Monitor: each edge sampled out of reset consumes at most one expectation.
    initial begin : monitor
        logic sampled;
        exp_t e;
        forever begin
            @(posedge clk);
            sampled = rst_n;
            #1;
            if (sampled && sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check(e.name, data_out, e.value);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rst_n   = 1'b0;
        rw      = 1'b1;
        addr    = '0;
        data_in = '0;
        ref_clear();

        // Scenario 1: reset state, then every address reads 0.
        #12;
        check("reset_out", data_out, '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) do_op(1'b1, i, '0, $sformatf("reset_rd%0d", i));

        // Scenario 2: read after reset.
        do_op(1'b1, 1, '0, "rd_after_reset");

        // Scenario 3: write, then read back. The write cycle must hold data_out.
        do_op(1'b0, 1, 32'hFFFF_FFFF, "wr_hold");
        do_op(1'b1, 1, '0, "wr_then_rd");

        // Scenario 4: isolation from address 1.
        do_op(1'b1, 4, '0, "isolation");

        // Scenario 5: boundary addresses.
        do_op(1'b0, 0, 32'hA5A5_A5A5, "wr_addr0");
        do_op(1'b0, 15, 32'h5A5A_5A5A, "wr_addr15");
        do_op(1'b1, 0, '0, "rd_addr0");
        do_op(1'b1, 15, '0, "rd_addr15");

        // Randomised traffic.
        for (int k = 0; k < 300; k++) begin
            do_op(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                  DW'($urandom), "random");
        end

        // Scenario 6: async reset pulse inside the high phase, away from any edge.
        // A write is left on the bus and must be discarded.
        do_op(1'b1, 0, '0, "pre_reset_rd0");
        @(negedge clk);
        rw      = 1'b0;
        addr    = 4'd7;
        data_in = 32'hDEAD_BEEF;
        wait_drain();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_out", data_out, '0);
        ref_clear();
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) do_op(1'b1, i, '0, $sformatf("post_reset_rd%0d", i));

        wait_drain();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
